gsm_free_list: RTL and testbench

- Ingress-side buffer manager directly upstream of the grouped-share-memory RAM stage.
- Keeps a FIFO free list of cell addresses.
- Allocates one address per accepted ingress cell and drives the RAM write port: write enable, address, data and multicast vector.
- Recycles addresses reported back by the RAM stage's buffer-free outputs.

---
 rtl/gsm_free_list_if.sv | 33 +++
 rtl/gsm_free_list.sv | 126 ++++++++++++
 tb/tb_gsm_free_list.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gsm_free_list_if.sv
// Bundle of the free-list manager's ingress cell, RAM write port, buffer-return and status signals.
interface gsm_free_list_if #(
   parameter int MWIDTH = 4,
   parameter int DWIDTH = 128,
   parameter int AWIDTH = 9
);
   logic              i_cell_valid;
   logic [DWIDTH-1:0] i_cell_data;
   logic [MWIDTH-1:0] i_multicast;
   logic              o_cell_ready;
   logic              o_wr_en;
   logic [AWIDTH-1:0] o_wr_addr;
   logic [DWIDTH-1:0] o_wr_data;
   logic [MWIDTH-1:0] o_multicast;
   logic              i_buf_free;
   logic [AWIDTH-1:0] i_buf_free_addr;
   logic [AWIDTH:0]   o_free_cnt;
   logic              o_init_done;
   logic              o_err_overflow;
   logic [15:0]       o_drop_cnt;

   modport slave (
      input  i_cell_valid, i_cell_data, i_multicast, i_buf_free, i_buf_free_addr,
      output o_cell_ready, o_wr_en, o_wr_addr, o_wr_data, o_multicast,
             o_free_cnt, o_init_done, o_err_overflow, o_drop_cnt
   );

   modport master (
      output i_cell_valid, i_cell_data, i_multicast, i_buf_free, i_buf_free_addr,
      input  o_cell_ready, o_wr_en, o_wr_addr, o_wr_data, o_multicast,
             o_free_cnt, o_init_done, o_err_overflow, o_drop_cnt
   );
endinterface

// File: rtl/gsm_free_list.sv
// FIFO free list of cell addresses feeding the grouped-share-memory RAM write port.
// Addresses are handed out in strict FIFO order and recycled from the RAM stage's buffer-free strobe.
module gsm_free_list #(
   parameter int MWIDTH = 4,
   parameter int DWIDTH = 128,
   parameter int AWIDTH = 9
) (
   input logic            clk,
   input logic            rst_n,
   gsm_free_list_if.slave bus
);
   localparam int                DEPTH   = 2 ** AWIDTH;
   localparam logic [AWIDTH:0]   L_DEPTH = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH-1:0] L_LAST  = {AWIDTH{1'b1}};

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t            r_state;
   logic [AWIDTH-1:0] r_list [DEPTH];
   logic [AWIDTH-1:0] r_rdPtr;
   logic [AWIDTH-1:0] r_wrPtr;
   logic [AWIDTH-1:0] r_initCnt;
   logic [AWIDTH:0]   r_freeCnt;
   logic              r_wrEn;
   logic [AWIDTH-1:0] r_wrAddr;
   logic [DWIDTH-1:0] r_wrData;
   logic [MWIDTH-1:0] r_multicast;
   logic              r_errOverflow;
   logic [15:0]       r_dropCnt;

   logic              w_run;
   logic              w_ready;
   logic              w_accept;
   logic              w_pop;
   logic              w_drop;
   logic              w_push;
   logic              w_ovf;
   logic              w_listWe;
   logic [AWIDTH-1:0] w_listWaddr;
   logic [AWIDTH-1:0] w_listWdata;

   assign w_run    = (r_state == ST_RUN);
   assign w_ready  = w_run && (r_freeCnt != '0);
   assign w_accept = bus.i_cell_valid && w_ready;
   assign w_pop    = w_accept && (bus.i_multicast != '0);
   assign w_drop   = w_accept && (bus.i_multicast == '0);

   // A return into a full list is still legal when the same cycle pops the head.
   assign w_push = w_run && bus.i_buf_free && ((r_freeCnt != L_DEPTH) || w_pop);
   assign w_ovf  = w_run && bus.i_buf_free && (r_freeCnt == L_DEPTH) && !w_pop;

   assign w_listWe    = rst_n && (!w_run || w_push);
   assign w_listWaddr = w_run ? r_wrPtr : r_initCnt;
   assign w_listWdata = w_run ? bus.i_buf_free_addr : r_initCnt;

   always_ff @(posedge clk) begin
      if (w_listWe) begin
         r_list[w_listWaddr] <= w_listWdata;
      end
   end

   // After INIT both pointers sit at 0 with the list full, so entry 0 is the first address issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_INIT;
         r_rdPtr       <= '0;
         r_wrPtr       <= '0;
         r_initCnt     <= '0;
         r_freeCnt     <= '0;
         r_wrEn        <= 1'b0;
         r_wrAddr      <= '0;
         r_wrData      <= '0;
         r_multicast   <= '0;
         r_errOverflow <= 1'b0;
         r_dropCnt     <= '0;
      end else begin
         r_wrEn <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_initCnt <= r_initCnt + 1'b1;
               r_freeCnt <= r_freeCnt + 1'b1;
               if (r_initCnt == L_LAST) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_pop) begin
                  r_wrEn      <= 1'b1;
                  r_wrAddr    <= r_list[r_rdPtr];
                  r_wrData    <= bus.i_cell_data;
                  r_multicast <= bus.i_multicast;
                  r_rdPtr     <= r_rdPtr + 1'b1;
               end
               if (w_drop && (r_dropCnt != 16'hFFFF)) begin
                  r_dropCnt <= r_dropCnt + 16'd1;
               end
               if (w_push) begin
                  r_wrPtr <= r_wrPtr + 1'b1;
               end
               if (w_ovf) begin
                  r_errOverflow <= 1'b1;
               end
               if (w_pop && !w_push) begin
                  r_freeCnt <= r_freeCnt - 1'b1;
               end else if (w_push && !w_pop) begin
                  r_freeCnt <= r_freeCnt + 1'b1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign bus.o_cell_ready   = w_ready;
   assign bus.o_wr_en        = r_wrEn;
   assign bus.o_wr_addr      = r_wrAddr;
   assign bus.o_wr_data      = r_wrData;
   assign bus.o_multicast    = r_multicast;
   assign bus.o_free_cnt     = r_freeCnt;
   assign bus.o_init_done    = w_run;
   assign bus.o_err_overflow = r_errOverflow;
   assign bus.o_drop_cnt     = r_dropCnt;
endmodule

// File: tb/tb_gsm_free_list.sv
// Bench for gsm_free_list: a queue-based free-list model checked every cycle, plus directed literal checks.
module tb_gsm_free_list;
   localparam int MW    = 4;
   localparam int DW    = 128;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int nChecks = 0;
   int nFails  = 0;

   gsm_free_list_if #(.MWIDTH(MW), .DWIDTH(DW), .AWIDTH(AW)) bus ();

   gsm_free_list #(.MWIDTH(MW), .DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: the free list is a plain queue; INIT appends 0..DEPTH-1 one per cycle.
   logic [AW-1:0] mQ[$];
   bit            modelLive = 1'b0;
   bit            mInit     = 1'b1;
   logic          mWrEn     = 1'b0;
   logic [AW-1:0] mWrAddr   = '0;
   logic [DW-1:0] mWrData   = '0;
   logic [MW-1:0] mMc       = '0;
   logic          mOvf      = 1'b0;
   logic [15:0]   mDrop     = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         mQ.delete();
         modelLive = 1'b1;
         mInit     = 1'b1;
         mWrEn     = 1'b0;
         mWrAddr   = '0;
         mWrData   = '0;
         mMc       = '0;
         mOvf      = 1'b0;
         mDrop     = '0;
      end else if (mInit) begin
         mQ.push_back(AW'(mQ.size()));
         mWrEn = 1'b0;
         if (mQ.size() == DEPTH) mInit = 1'b0;
      end else begin
         bit canTake;
         canTake = (mQ.size() != 0);
         mWrEn   = 1'b0;
         if (bus.i_cell_valid && canTake) begin
            if (bus.i_multicast != '0) begin
               mWrEn   = 1'b1;
               mWrAddr = mQ.pop_front();
               mWrData = bus.i_cell_data;
               mMc     = bus.i_multicast;
            end else if (mDrop != 16'hFFFF) begin
               mDrop = mDrop + 16'd1;
            end
         end
         if (bus.i_buf_free) begin
            if (mQ.size() < DEPTH) mQ.push_back(bus.i_buf_free_addr);
            else mOvf = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("m_cell_ready", 128'(bus.o_cell_ready), 128'(!mInit && (mQ.size() != 0)));
         checkOutput("m_wr_en", 128'(bus.o_wr_en), 128'(mWrEn));
         checkOutput("m_free_cnt", 128'(bus.o_free_cnt), 128'(mQ.size()));
         checkOutput("m_init_done", 128'(bus.o_init_done), 128'(!mInit));
         checkOutput("m_err_overflow", 128'(bus.o_err_overflow), 128'(mOvf));
         checkOutput("m_drop_cnt", 128'(bus.o_drop_cnt), 128'(mDrop));
         if (mWrEn) begin
            checkOutput("m_wr_addr", 128'(bus.o_wr_addr), 128'(mWrAddr));
            checkOutput("m_wr_data", 128'(bus.o_wr_data), 128'(mWrData));
            checkOutput("m_multicast", 128'(bus.o_multicast), 128'(mMc));
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [MW-1:0] mc,
                                input logic bf, input logic [AW-1:0] ba);
      bus.i_cell_valid    = v;
      bus.i_cell_data     = d;
      bus.i_multicast     = mc;
      bus.i_buf_free      = bf;
      bus.i_buf_free_addr = ba;
      @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, 128'(bus.o_cell_ready), 128'(0));
      checkOutput({tag, "_wr_en"}, 128'(bus.o_wr_en), 128'(0));
      checkOutput({tag, "_wr_addr"}, 128'(bus.o_wr_addr), 128'(0));
      checkOutput({tag, "_wr_data"}, 128'(bus.o_wr_data), 128'(0));
      checkOutput({tag, "_multicast"}, 128'(bus.o_multicast), 128'(0));
      checkOutput({tag, "_free_cnt"}, 128'(bus.o_free_cnt), 128'(0));
      checkOutput({tag, "_init_done"}, 128'(bus.o_init_done), 128'(0));
      checkOutput({tag, "_overflow"}, 128'(bus.o_err_overflow), 128'(0));
      checkOutput({tag, "_drop_cnt"}, 128'(bus.o_drop_cnt), 128'(0));
   endtask

   initial begin
      bus.i_cell_valid    = 1'b0;
      bus.i_cell_data     = '0;
      bus.i_multicast     = '0;
      bus.i_buf_free      = 1'b0;
      bus.i_buf_free_addr = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");

      // Initialisation timing; a return during INIT must be ignored.
      rst_n = 1'b1;
      for (int c = 1; c <= DEPTH; c++) begin
         applyStimulus(1'b0, '0, '0, (c == 100), 9'd42);
         if (c == 511) begin
            checkOutput("init_done_at_511", 128'(bus.o_init_done), 128'(0));
            checkOutput("free_cnt_at_511", 128'(bus.o_free_cnt), 128'(511));
         end
      end
      checkOutput("init_done_at_512", 128'(bus.o_init_done), 128'(1));
      checkOutput("free_cnt_at_512", 128'(bus.o_free_cnt), 128'(512));
      checkOutput("ready_at_512", 128'(bus.o_cell_ready), 128'(1));
      checkOutput("no_ovf_from_init_return", 128'(bus.o_err_overflow), 128'(0));

      applyStimulus(1'b0, '0, '0, 1'b1, 9'd5);
      checkOutput("ovf_full_return", 128'(bus.o_err_overflow), 128'(1));
      checkOutput("free_after_ovf", 128'(bus.o_free_cnt), 128'(512));

      applyStimulus(1'b1, 128'hA1, 4'b0001, 1'b0, '0);
      checkOutput("cell0_wr_en", 128'(bus.o_wr_en), 128'(1));
      checkOutput("cell0_addr", 128'(bus.o_wr_addr), 128'(0));
      checkOutput("cell0_mc", 128'(bus.o_multicast), 128'(4'b0001));
      checkOutput("cell0_data", 128'(bus.o_wr_data), 128'hA1);
      applyStimulus(1'b1, 128'hB2, 4'b0110, 1'b0, '0);
      checkOutput("cell1_addr", 128'(bus.o_wr_addr), 128'(1));
      checkOutput("cell1_mc", 128'(bus.o_multicast), 128'(4'b0110));
      applyStimulus(1'b1, 128'hC3, 4'b1111, 1'b0, '0);
      checkOutput("cell2_addr", 128'(bus.o_wr_addr), 128'(2));
      checkOutput("cell2_mc", 128'(bus.o_multicast), 128'(4'b1111));
      checkOutput("free_after_3", 128'(bus.o_free_cnt), 128'(509));
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      checkOutput("wr_en_idle", 128'(bus.o_wr_en), 128'(0));

      // Drain the list completely, then recycle a single address.
      for (int i = 0; i < 509; i++) applyStimulus(1'b1, 128'(i + 1000), 4'b0001, 1'b0, '0);
      checkOutput("last_addr", 128'(bus.o_wr_addr), 128'(511));
      checkOutput("empty_free_cnt", 128'(bus.o_free_cnt), 128'(0));
      checkOutput("empty_ready", 128'(bus.o_cell_ready), 128'(0));
      applyStimulus(1'b1, 128'hDEAD, 4'b0001, 1'b0, '0);
      checkOutput("empty_no_write", 128'(bus.o_wr_en), 128'(0));
      applyStimulus(1'b0, '0, '0, 1'b1, 9'd7);
      checkOutput("ready_after_return", 128'(bus.o_cell_ready), 128'(1));
      applyStimulus(1'b1, 128'hBEEF, 4'b0010, 1'b0, '0);
      checkOutput("reissue_7", 128'(bus.o_wr_addr), 128'(7));

      // Build 100 free entries, then pop and push together.
      for (int a = 10; a < 110; a++) applyStimulus(1'b0, '0, '0, 1'b1, 9'(a));
      checkOutput("free_100", 128'(bus.o_free_cnt), 128'(100));
      applyStimulus(1'b1, 128'h300, 4'b0100, 1'b1, 9'd300);
      checkOutput("free_100_popush", 128'(bus.o_free_cnt), 128'(100));
      checkOutput("popush_addr", 128'(bus.o_wr_addr), 128'(10));
      for (int i = 0; i < 99; i++) applyStimulus(1'b1, 128'(i), 4'b1000, 1'b0, '0);
      checkOutput("addr_109", 128'(bus.o_wr_addr), 128'(109));
      applyStimulus(1'b1, 128'h77, 4'b1000, 1'b0, '0);
      checkOutput("addr_300_last", 128'(bus.o_wr_addr), 128'(300));
      checkOutput("free_0_again", 128'(bus.o_free_cnt), 128'(0));

      applyStimulus(1'b0, '0, '0, 1'b1, 9'd11);
      applyStimulus(1'b1, 128'h55, 4'b0000, 1'b0, '0);
      checkOutput("drop_no_write", 128'(bus.o_wr_en), 128'(0));
      checkOutput("drop_cnt_1", 128'(bus.o_drop_cnt), 128'(1));
      checkOutput("drop_free_same", 128'(bus.o_free_cnt), 128'(1));

      // Leave 200 addresses outstanding, then reset with traffic still flowing.
      for (int a = 200; a < 512; a++) applyStimulus(1'b0, '0, '0, 1'b1, 9'(a));
      applyStimulus(1'b1, 128'h66, 4'b0011, 1'b0, '0);
      checkOutput("pre_reset_addr", 128'(bus.o_wr_addr), 128'(11));
      checkOutput("pre_reset_free", 128'(bus.o_free_cnt), 128'(312));
      rst_n = 1'b0;
      applyStimulus(1'b1, 128'h67, 4'b0011, 1'b0, '0);
      checkAllZero("midreset");
      rst_n = 1'b1;
      for (int c = 1; c <= DEPTH; c++) applyStimulus(1'b0, '0, '0, 1'b0, '0);
      checkOutput("reinit_free", 128'(bus.o_free_cnt), 128'(512));
      checkOutput("reinit_done", 128'(bus.o_init_done), 128'(1));
      applyStimulus(1'b1, 128'h99, 4'b0101, 1'b0, '0);
      checkOutput("reinit_first_addr", 128'(bus.o_wr_addr), 128'(0));
      checkOutput("reinit_first_wr_en", 128'(bus.o_wr_en), 128'(1));
      applyStimulus(1'b0, '0, '0, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
